// File: rtl/bus_sequencer.sv
// bus_sequencer
// Multi-cycle control sequencer for the 16-bit datapath. It walks each
// instruction through FETCH -> DECODE -> EXEC (-> LOADWB for loads). It drives
// the writeback bus source select and every destination write strobe: register
// file, data memory, instruction register, PC and PSR flags.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high; forces FETCH on the next edge
//   hold       : stall; freezes state and forces all strobes to 0
//   instr[15:0]: instruction register contents
//                [15:12] op, [11:8] Rdest, [7:4] opext, [3:0] Rsrc
//   selector   : bus source 000 ALU, 001 shift, 010 imm, 011 mem, 100 PC, 101 regB
//   ir_we      : latch memory output into the instruction register
//   reg_we     : write bus value to Rdest
//   mem_we     : write register A to data memory
//   addr_sel   : memory address source, 0 PC, 1 register B
//   pc_inc     : PC <= PC + 1
//   pc_load    : PC <= register B
//   flag_we    : update PSR flags from the ALU
//   illegal    : one-cycle pulse on an undecodable instruction
//   state_dbg  : current state encoding
module bus_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic [15:0] instr,
  output logic [2:0]  selector,
  output logic        ir_we,
  output logic        reg_we,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        flag_we,
  output logic        illegal,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'b000,
    ST_DECODE = 3'b001,
    ST_EXEC   = 3'b010,
    ST_LOADWB = 3'b011
  } state_t;

  localparam logic [2:0] SEL_ALU   = 3'b000;
  localparam logic [2:0] SEL_SHIFT = 3'b001;
  localparam logic [2:0] SEL_IMM   = 3'b010;
  localparam logic [2:0] SEL_MEM   = 3'b011;
  localparam logic [2:0] SEL_PC    = 3'b100;
  localparam logic [2:0] SEL_REGB  = 3'b101;

  typedef struct packed {
    logic [2:0] sel;
    logic       ir_we;
    logic       reg_we;
    logic       mem_we;
    logic       addr_sel;
    logic       pc_inc;
    logic       pc_load;
    logic       flag_we;
    logic       illegal;
  } ctl_t;

  state_t state_r;
  state_t next_state_s;
  ctl_t   raw_s;
  ctl_t   out_s;

  // ALU operation codes. These are shared by the register form (opext) and
  // the immediate form (op).
  function automatic logic is_alu_code(input logic [3:0] code);
    logic hit;
    case (code)
      4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1001: hit = 1'b1;
      default:                                     hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Only ADD and SUB forms update the PSR flags.
  function automatic logic is_arith_code(input logic [3:0] code);
    return (code == 4'b0101) || (code == 4'b1001);
  endfunction

  function automatic logic is_load_instr(input logic [15:0] ir);
    return (ir[15:12] == 4'b0100) && (ir[7:4] == 4'b0000);
  endfunction

  // EXEC-state control for one instruction. Exactly one class matches.
  function automatic ctl_t exec_decode(input logic [15:0] ir);
    logic [3:0] op;
    logic [3:0] ext;
    ctl_t       c;
    op  = ir[15:12];
    ext = ir[7:4];
    c   = '0;
    if ((op == 4'b0000) && is_alu_code(ext)) begin
      c.sel     = SEL_ALU;
      c.reg_we  = 1'b1;
      c.flag_we = is_arith_code(ext);
      c.pc_inc  = 1'b1;
    end else if (is_alu_code(op)) begin
      c.sel     = SEL_ALU;
      c.reg_we  = 1'b1;
      c.flag_we = is_arith_code(op);
      c.pc_inc  = 1'b1;
    end else if (((op == 4'b0000) && (ext == 4'b1011)) || (op == 4'b1011)) begin
      c.flag_we = 1'b1;
      c.pc_inc  = 1'b1;
    end else if ((op == 4'b0000) && (ext == 4'b1101)) begin
      c.sel     = SEL_REGB;
      c.reg_we  = 1'b1;
      c.pc_inc  = 1'b1;
    end else if ((op == 4'b1101) || (op == 4'b1111)) begin
      c.sel     = SEL_IMM;
      c.reg_we  = 1'b1;
      c.pc_inc  = 1'b1;
    end else if ((op == 4'b1000) && ((ext == 4'b0100) || (ext[3:1] == 3'b000))) begin
      c.sel     = SEL_SHIFT;
      c.reg_we  = 1'b1;
      c.pc_inc  = 1'b1;
    end else if ((op == 4'b0100) && (ext == 4'b0100)) begin
      c.addr_sel = 1'b1;
      c.mem_we   = 1'b1;
      c.pc_inc   = 1'b1;
    end else if ((op == 4'b0100) && (ext == 4'b0000)) begin
      // Load: present Rsrc as the address now; the data returns in LOADWB.
      c.addr_sel = 1'b1;
    end else if ((op == 4'b0100) && (ext == 4'b1000)) begin
      // JAL writes the return address and redirects the PC, so no increment.
      c.sel     = SEL_PC;
      c.reg_we  = 1'b1;
      c.pc_load = 1'b1;
    end else begin
      c.illegal = 1'b1;
      c.pc_inc  = 1'b1;
    end
    return c;
  endfunction

  // State register: reset wins over hold, and hold freezes the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_FETCH;
    end else if (hold) begin
      state_r <= state_r;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic and ungated control for the current state.
  always_comb begin
    next_state_s = ST_FETCH;
    raw_s        = '0;
    case (state_r)
      ST_FETCH: begin
        raw_s.addr_sel = 1'b0;
        next_state_s   = ST_DECODE;
      end
      ST_DECODE: begin
        raw_s.addr_sel = 1'b0;
        raw_s.ir_we    = 1'b1;
        next_state_s   = ST_EXEC;
      end
      ST_EXEC: begin
        raw_s = exec_decode(instr);
        if (is_load_instr(instr)) begin
          next_state_s = ST_LOADWB;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_LOADWB: begin
        raw_s.addr_sel = 1'b1;
        raw_s.sel      = SEL_MEM;
        raw_s.reg_we   = 1'b1;
        raw_s.pc_inc   = 1'b1;
        next_state_s   = ST_FETCH;
      end
      default: begin
        // Corrupted encoding: stay quiet for one cycle and restart at FETCH.
        raw_s        = '0;
        next_state_s = ST_FETCH;
      end
    endcase
  end

  // Output gating. Hold keeps selector and addr_sel so the memory address
  // stays stable while stalled. Reset clears everything.
  always_comb begin
    out_s = '0;
    if (reset) begin
      out_s = '0;
    end else if (hold) begin
      out_s.sel      = raw_s.sel;
      out_s.addr_sel = raw_s.addr_sel;
    end else begin
      out_s = raw_s;
    end
  end

  assign selector  = out_s.sel;
  assign ir_we     = out_s.ir_we;
  assign reg_we    = out_s.reg_we;
  assign mem_we    = out_s.mem_we;
  assign addr_sel  = out_s.addr_sel;
  assign pc_inc    = out_s.pc_inc;
  assign pc_load   = out_s.pc_load;
  assign flag_we   = out_s.flag_we;
  assign illegal   = out_s.illegal;
  assign state_dbg = state_r;

endmodule
